pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/stretch_pkg.sv | 24 ++
 rtl/cycle_timer.sv | 33 +++
 rtl/pulse_stretcher.sv | 129 ++++++++++++
 tb/tb_pulse_stretcher.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stretch_pkg.sv
// ============================================================================
// stretch_pkg : shared FSM state type and counter-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Width needed to hold max(hold, gap) - 1, never narrower than one bit.
    function automatic int cnt_width(input int hold_c, input int gap_c);
        int m;
        m = (hold_c > gap_c) ? hold_c : gap_c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ============================================================================
// cycle_timer : loadable down-counter with zero detect, idles at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module cycle_timer #(
    parameter int W = 2
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// pulse_stretcher : stretches single-cycle pulses into HOLD/GAP led intervals,
// queueing pulses that arrive while busy. Macro PULSE_STRETCHER_OVF_EN adds
// a sticky overflow flag. Rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher
    import stretch_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              pulse,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int                CNT_W       = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0]  C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] C_PEND_MAX  = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_led;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_zero;
    logic              w_enq;

    cycle_timer #(.W(CNT_W)) u_timer (
        .Clock    (Clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_enq       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pulse) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = C_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                w_enq = pulse;
                if (w_zero) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = C_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    // A pulse on the exit edge is consumed directly or swaps with a queued one.
                    if (r_pend != '0 || pulse) begin
                        w_state_nxt = ST_HOLD;
                        w_load      = 1'b1;
                        w_load_val  = C_HOLD_LOAD;
                        if (r_pend != '0 && !pulse) begin
                            w_pend_nxt = r_pend - PEND_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_enq = pulse;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_enq && r_pend != C_PEND_MAX) begin
            w_pend_nxt = r_pend + PEND_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_led   <= (w_state_nxt == ST_HOLD);
        end
    end

    assign led     = r_led;
    assign busy    = (r_state != ST_IDLE);
    assign pending = r_pend;

`ifdef PULSE_STRETCHER_OVF_EN
    logic r_ovf;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_enq && r_pend == C_PEND_MAX) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// tb_pulse_stretcher : three parameterisations against a remaining-cycles model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

    typedef struct {
        int hl;     // led-high cycles remaining, including current
        int gl;     // forced-low cycles remaining, including current
        int p;
        bit ovf;
        int holds;
    } mdl_t;

    logic       clk;
    logic       reset;
    logic       pulse0, pulse1, pulse2;
    logic       led0, led1, led2;
    logic       busy0, busy1, busy2;
    logic [2:0] pend0;
    logic [1:0] pend1;
    logic [2:0] pend2;
    logic       ovf0, ovf1, ovf2;

    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 0;
    int   rise1 = 0;
    logic led1_q = 1'b0;
    mdl_t m0, m1, m2;

    pulse_stretcher u0 (
        .Clock(clk), .reset(reset), .pulse(pulse0), .led(led0),
        .busy(busy0), .pending(pend0), .overflow(ovf0)
    );
    pulse_stretcher #(.PEND_W(2)) u1 (
        .Clock(clk), .reset(reset), .pulse(pulse1), .led(led1),
        .busy(busy1), .pending(pend1), .overflow(ovf1)
    );
    pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) u2 (
        .Clock(clk), .reset(reset), .pulse(pulse2), .led(led2),
        .busy(busy2), .pending(pend2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mdl_reset(input mdl_t m);
        mdl_t n = m;
        n.hl = 0; n.gl = 0; n.p = 0; n.ovf = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit pl,
                                      input int h, input int g, input int pmax);
        mdl_t n = m;
        bit   enq = 1'b0;
        if (m.hl == 0 && m.gl == 0) begin
            if (pl) begin n.hl = h; n.holds++; end
        end else if (m.hl > 0) begin
            if (m.hl > 1) n.hl = m.hl - 1;
            else begin n.hl = 0; n.gl = g; end
            enq = pl;
        end else if (m.gl > 1) begin
            n.gl = m.gl - 1;
            enq = pl;
        end else begin
            n.gl = 0;
            if (m.p > 0 || pl) begin
                n.hl = h; n.holds++;
                if (m.p > 0 && !pl) n.p = m.p - 1;
            end
        end
        if (enq) begin
            if (n.p < pmax) n.p++;
            else n.ovf = 1'b1;
        end
        return n;
    endfunction

    function automatic int ovf_exp(input bit o);
`ifdef PULSE_STRETCHER_OVF_EN
        return int'(o);
`else
        return 0;
`endif
    endfunction

    initial begin
        m0 = '{0, 0, 0, 1'b0, 0};
        m1 = '{0, 0, 0, 1'b0, 0};
        m2 = '{0, 0, 0, 1'b0, 0};
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0 <= mdl_reset(m0);
            m1 <= mdl_reset(m1);
            m2 <= mdl_reset(m2);
        end else begin
            m0 <= mdl_step(m0, pulse0, 4, 2, 7);
            m1 <= mdl_step(m1, pulse1, 4, 2, 3);
            m2 <= mdl_step(m2, pulse2, 1, 1, 7);
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("led0",  led0,  int'(m0.hl > 0));
            cmp("busy0", busy0, int'(m0.hl > 0 || m0.gl > 0));
            cmp("pend0", pend0, m0.p);
            cmp("ovf0",  ovf0,  ovf_exp(m0.ovf));
            cmp("led1",  led1,  int'(m1.hl > 0));
            cmp("busy1", busy1, int'(m1.hl > 0 || m1.gl > 0));
            cmp("pend1", pend1, m1.p);
            cmp("ovf1",  ovf1,  ovf_exp(m1.ovf));
            cmp("led2",  led2,  int'(m2.hl > 0));
            cmp("busy2", busy2, int'(m2.hl > 0 || m2.gl > 0));
            cmp("pend2", pend2, m2.p);
            cmp("ovf2",  ovf2,  ovf_exp(m2.ovf));
        end
        if (led1 && !led1_q) rise1 <= rise1 + 1;
        led1_q <= led1;
    end

    // Inputs for the next edge; returns at the following negedge.
    task automatic step(input bit a, input bit b, input bit c);
        pulse0 = a; pulse1 = b; pulse2 = c;
        @(negedge clk);
    endtask

    task automatic async_reset();
        pulse0 = 1'b0; pulse1 = 1'b0; pulse2 = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        cmp("ar_led0",  led0,  0);
        cmp("ar_busy0", busy0, 0);
        cmp("ar_pend0", pend0, 0);
        cmp("ar_busy1", busy1, 0);
        cmp("ar_pend1", pend1, 0);
        cmp("ar_ovf1",  ovf1,  0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit [6:0] led_lit;
        bit [6:0] busy_lit;
        bit [5:0] led2_lit;
        int       pend2_lit [6];
        int       dens0, dens1, dens2;

        led_lit   = 7'b0001111;
        busy_lit  = 7'b0111111;
        led2_lit  = 6'b010101;
        pend2_lit = '{0, 1, 1, 2, 2, 3};

        reset = 1'b0;
        pulse0 = 1'b0; pulse1 = 1'b0; pulse2 = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_led0",  led0,  0);
        cmp("rst_busy0", busy0, 0);
        cmp("rst_pend0", pend0, 0);
        cmp("rst_ovf0",  ovf0,  0);
        reset = 1'b1;
        chk_on = 1'b1;

        // Single pulse: 4 high, 2 low, then idle.
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(i == 0, 0, 0);
            cmp("one_led",  led0,  led_lit[i]);
            cmp("one_busy", busy0, busy_lit[i]);
            cmp("one_pend", pend0, 0);
        end

        // Three back-to-back pulses queue two.
        step(1, 0, 0); cmp("q3_p0", pend0, 0);
        step(1, 0, 0); cmp("q3_p1", pend0, 1);
        step(1, 0, 0); cmp("q3_p2", pend0, 2);
        repeat (3) step(0, 0, 0);
        step(0, 0, 0);
        cmp("q3_exit_led", led0, 1);
        cmp("q3_exit_pend", pend0, 1);
        repeat (20) step(0, 0, 0);
        cmp("q3_drain_busy", busy0, 0);

        // Pulse on the GAP-exit edge with one queued.
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        cmp("gx_led", led0, 1);
        cmp("gx_pend", pend0, 1);
        repeat (20) step(0, 0, 0);

        // HOLD=GAP=1 with a pulse every cycle.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            cmp("alt_led",  led2,  led2_lit[i]);
            cmp("alt_pend", pend2, pend2_lit[i]);
        end
        repeat (30) step(0, 0, 0);

        // PEND_W=2 saturation with a level held for 10 cycles.
        repeat (10) step(0, 1, 0);
        cmp("sat_pend", pend1, 3);
`ifdef PULSE_STRETCHER_OVF_EN
        cmp("sat_ovf", ovf1, 1);
`else
        cmp("sat_ovf", ovf1, 0);
`endif
        repeat (40) step(0, 0, 0);
        cmp("sat_holds", rise1, m1.holds);
        cmp("sat_idle", busy1, 0);

        // Async reset mid-HOLD with work queued, then restart.
        step(1, 0, 0);
        step(1, 0, 0);
        async_reset();
        step(1, 0, 0);
        cmp("post_rst_led", led0, 1);
        cmp("post_rst_pend", pend0, 0);
        repeat (10) step(0, 0, 0);

        // Randomised traffic with varying densities and occasional resets.
        dens0 = 0; dens1 = 0; dens2 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) begin
                dens0 = $urandom_range(0, 100);
                dens1 = $urandom_range(0, 100);
                dens2 = $urandom_range(0, 100);
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 99) < dens0,
                     $urandom_range(0, 99) < dens1,
                     $urandom_range(0, 99) < dens2);
            end
        end
        repeat (60) step(0, 0, 0);
        cmp("final_holds1", rise1, m1.holds);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
